// File: rtl/int_div_seq.sv
// Iterative restoring divider: one quotient bit per cycle using an external subtractor.
// Optional two's-complement operation is enabled by defining INT_DIV_SIGNED_EN.
module int_div_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] dv;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic             dz;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

`ifdef INT_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // The core only ever sees magnitudes; most-negative maps onto itself, read as unsigned.
  assign op_a    = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign op_b    = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign q_final = neg_q ? (~q + 1'b1) : q;
  assign r_final = neg_r ? (~rem + 1'b1) : rem;
`else
  assign op_a    = dividend;
  assign op_b    = divisor;
  assign q_final = q;
  assign r_final = rem;
`endif

  // The partial remainder is below both dv and 2^i here, so the shift never loses a bit.
  assign shifted = {rem[WIDTH-2:0], q[WIDTH-1]};
  assign sub_a   = (state == RUN) ? shifted : '0;
  assign sub_b   = (state == RUN) ? dv : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dv          <= '0;
      q           <= '0;
      rem         <= '0;
      count       <= '0;
      dz          <= 1'b0;
`ifdef INT_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle showing done belongs to the finishing operation, so start waits one more.
          if (start && !done) begin
            busy <= 1'b1;
            rem  <= '0;
`ifdef INT_DIV_SIGNED_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              dz    <= 1'b1;
              q     <= dividend;
              dv    <= '0;
              count <= '0;
              state <= FIN;
            end else begin
              dz    <= 1'b0;
              q     <= op_a;
              dv    <= op_b;
              count <= CW'(WIDTH);
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem   <= sub_bout ? shifted : sub_diff;
          q     <= {q[WIDTH-2:0], ~sub_bout};
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (dz) begin
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
